mem_array_with_crc: RTL



---
 rtl/mem_crc_pkg.sv | 44 ++++
 rtl/mem_array_with_crc_if.sv | 40 ++++
 rtl/mem_crc_gen.sv | 23 ++
 rtl/mem_array_with_crc.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_crc_pkg.sv
// Shared types, limits and the CRC helper for the CRC-protected memory array.
// crc_calc is bit-serial, MSB-first, non-reflected, with no final XOR.
package mem_crc_pkg;

    localparam int CRC_MAX_W  = 32;
    localparam int DATA_MAX_W = 64;

    localparam logic [7:0] ERR_CNT_MAX = 8'd255;

    typedef enum logic [1:0] {
        SCRUB_IDLE,
        SCRUB_READ,
        SCRUB_CHECK
    } scrub_state_t;

    typedef enum logic {
        ERR_SRC_READ,
        ERR_SRC_SCRUB
    } err_src_t;

    // The width, polynomial and seed arguments are elaboration-time constants.
    // Data bits at or above dw are ignored.
    function automatic logic [CRC_MAX_W-1:0] crc_calc(
        input logic [DATA_MAX_W-1:0] data,
        input int                    dw,
        input int                    pw,
        input logic [CRC_MAX_W-1:0]  poly,
        input logic [CRC_MAX_W-1:0]  init
    );
        logic [CRC_MAX_W-1:0] c;
        logic [CRC_MAX_W-1:0] m;
        logic                 fb;
        m = {CRC_MAX_W{1'b1}} >> (CRC_MAX_W - pw);
        c = init & m;
        for (int i = DATA_MAX_W - 1; i >= 0; i--) begin
            if (i < dw) begin
                fb = c[pw-1] ^ data[i];
                c  = ((c << 1) ^ (fb ? poly : '0)) & m;
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/mem_array_with_crc_if.sv
// Port bundle of the CRC-protected memory array.
// The master drives strobes and data; the slave returns reads, errors and status.
interface mem_array_with_crc_if #(
    parameter int DATA_WIDTH = 8,
    parameter int AW         = 4
);
    logic                  wr_en;
    logic [AW-1:0]         wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  inj_en;
    logic [DATA_WIDTH-1:0] inj_mask;
    logic                  rd_en;
    logic [AW-1:0]         rd_addr;
    logic                  rd_valid;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_crc_err;
    logic                  err_valid;
    logic [AW-1:0]         err_addr;
    logic                  err_src;
    logic [7:0]            err_count;
    logic                  err_clr;
    logic                  scrub_done;

    modport master (
        output wr_en, wr_addr, wr_data, inj_en, inj_mask,
        output rd_en, rd_addr, err_clr,
        input  rd_valid, rd_data, rd_crc_err,
        input  err_valid, err_addr, err_src, err_count,
        input  scrub_done
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, inj_en, inj_mask,
        input  rd_en, rd_addr, err_clr,
        output rd_valid, rd_data, rd_crc_err,
        output err_valid, err_addr, err_src, err_count,
        output scrub_done
    );

endinterface

// File: rtl/mem_crc_gen.sv
// Combinational CRC generator over one data word.
// Used on the write path, the read check and the scrub check.
module mem_crc_gen
    import mem_crc_pkg::*;
#(
    parameter int                         DATA_WIDTH      = 8,
    parameter int                         POLYNOMIAL_BITS = 8,
    parameter logic [POLYNOMIAL_BITS-1:0] POLYNOMIAL      = 8'h07,
    parameter logic [POLYNOMIAL_BITS-1:0] CRC_INIT        = '0
) (
    input  logic [DATA_WIDTH-1:0]      data,
    output logic [POLYNOMIAL_BITS-1:0] crc
);

    assign crc = POLYNOMIAL_BITS'(crc_calc(
        DATA_MAX_W'(data),
        DATA_WIDTH,
        POLYNOMIAL_BITS,
        CRC_MAX_W'(POLYNOMIAL),
        CRC_MAX_W'(CRC_INIT)
    ));

endmodule

// File: rtl/mem_array_with_crc.sv
// CRC-protected memory array with read checking, idle-time scrubbing,
// fault injection and a saturating error counter.
module mem_array_with_crc
    import mem_crc_pkg::*;
#(
    parameter int                         DATA_WIDTH      = 8,
    parameter int                         DEPTH           = 16,
    parameter int                         POLYNOMIAL_BITS = 8,
    parameter logic [POLYNOMIAL_BITS-1:0] POLYNOMIAL      = 8'h07,
    parameter logic [POLYNOMIAL_BITS-1:0] CRC_INIT        = '0,
    parameter int                         SCRUB_INTERVAL  = 64
) (
    input  logic                clk,
    input  logic                rst,
    mem_array_with_crc_if.slave bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = (SCRUB_INTERVAL > 1) ? $clog2(SCRUB_INTERVAL) : 1;
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [CW-1:0] IDLE_LAST = CW'(SCRUB_INTERVAL - 1);

    // CRC of an all-zero word, so that reset contents check clean.
    localparam logic [POLYNOMIAL_BITS-1:0] CRC_ZERO =
        POLYNOMIAL_BITS'(crc_calc('0, DATA_WIDTH, POLYNOMIAL_BITS,
                                  CRC_MAX_W'(POLYNOMIAL),
                                  CRC_MAX_W'(CRC_INIT)));

    logic [DATA_WIDTH-1:0]      mem     [DEPTH];
    logic [POLYNOMIAL_BITS-1:0] crc_mem [DEPTH];

    logic [POLYNOMIAL_BITS-1:0] wr_crc;
    logic [POLYNOMIAL_BITS-1:0] rd_calc;
    logic [POLYNOMIAL_BITS-1:0] sc_calc;
    logic [DATA_WIDTH-1:0]      rd_word;
    logic [DATA_WIDTH-1:0]      sc_data;
    logic [POLYNOMIAL_BITS-1:0] sc_crc;

    scrub_state_t   state;
    scrub_state_t   state_nxt;
    logic [CW-1:0]  idle_cnt;
    logic [CW-1:0]  idle_cnt_nxt;
    logic [AW-1:0]  scrub_addr;
    logic [AW-1:0]  scrub_addr_nxt;
    logic           sc_cap;
    logic           sc_mis;
    logic           done_nxt;

    logic           access;
    logic           rd_err_nxt;
    logic           ev_sc;
    logic           ev_any;

    assign access     = bus.rd_en | bus.wr_en;
    assign rd_word    = mem[bus.rd_addr];
    assign rd_err_nxt = bus.rd_en && (rd_calc != crc_mem[bus.rd_addr]);
    assign ev_sc      = (state == SCRUB_CHECK) && sc_mis;
    assign ev_any     = rd_err_nxt | ev_sc;

    mem_crc_gen #(
        .DATA_WIDTH      (DATA_WIDTH),
        .POLYNOMIAL_BITS (POLYNOMIAL_BITS),
        .POLYNOMIAL      (POLYNOMIAL),
        .CRC_INIT        (CRC_INIT)
    ) u_wr_gen (
        .data (bus.wr_data),
        .crc  (wr_crc)
    );

    mem_crc_gen #(
        .DATA_WIDTH      (DATA_WIDTH),
        .POLYNOMIAL_BITS (POLYNOMIAL_BITS),
        .POLYNOMIAL      (POLYNOMIAL),
        .CRC_INIT        (CRC_INIT)
    ) u_rd_gen (
        .data (rd_word),
        .crc  (rd_calc)
    );

    mem_crc_gen #(
        .DATA_WIDTH      (DATA_WIDTH),
        .POLYNOMIAL_BITS (POLYNOMIAL_BITS),
        .POLYNOMIAL      (POLYNOMIAL),
        .CRC_INIT        (CRC_INIT)
    ) u_sc_gen (
        .data (sc_data),
        .crc  (sc_calc)
    );

    // Storage: data may be corrupted by injection, CRC always covers clean data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i]     <= '0;
                crc_mem[i] <= CRC_ZERO;
            end
        end else if (bus.wr_en) begin
            mem[bus.wr_addr]     <= bus.wr_data
                                  ^ (bus.inj_en ? bus.inj_mask : '0);
            crc_mem[bus.wr_addr] <= wr_crc;
        end
    end

    // Scrubber next state: yields to any functional access, never stalls it.
    always_comb begin
        state_nxt      = state;
        idle_cnt_nxt   = idle_cnt;
        scrub_addr_nxt = scrub_addr;
        sc_cap         = 1'b0;
        sc_mis         = 1'b0;
        done_nxt       = 1'b0;
        unique case (state)
            SCRUB_IDLE: begin
                if (access) begin
                    idle_cnt_nxt = '0;
                end else if (idle_cnt == IDLE_LAST) begin
                    idle_cnt_nxt = '0;
                    state_nxt    = SCRUB_READ;
                end else begin
                    idle_cnt_nxt = idle_cnt + CW'(1);
                end
            end
            SCRUB_READ: begin
                if (!access) begin
                    sc_cap    = 1'b1;
                    state_nxt = SCRUB_CHECK;
                end
            end
            SCRUB_CHECK: begin
                sc_mis    = (sc_calc != sc_crc);
                state_nxt = SCRUB_IDLE;
                // A scrub error shadowed by a read error is retried next pass.
                if (!(sc_mis && rd_err_nxt)) begin
                    scrub_addr_nxt = scrub_addr + AW'(1);
                    done_nxt       = (scrub_addr == LAST_ADDR);
                end
            end
            default: begin
                state_nxt    = SCRUB_IDLE;
                idle_cnt_nxt = '0;
            end
        endcase
    end

    // Scrubber state, idle counter, address and captured word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= SCRUB_IDLE;
            idle_cnt   <= '0;
            scrub_addr <= '0;
            sc_data    <= '0;
            sc_crc     <= CRC_ZERO;
        end else begin
            state      <= state_nxt;
            idle_cnt   <= idle_cnt_nxt;
            scrub_addr <= scrub_addr_nxt;
            if (sc_cap) begin
                sc_data <= mem[scrub_addr];
                sc_crc  <= crc_mem[scrub_addr];
            end
        end
    end

    // Registered read response, one cycle after rd_en.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.rd_valid   <= 1'b0;
            bus.rd_data    <= '0;
            bus.rd_crc_err <= 1'b0;
        end else begin
            bus.rd_valid   <= bus.rd_en;
            bus.rd_crc_err <= rd_err_nxt;
            if (bus.rd_en) begin
                bus.rd_data <= rd_word;
            end
        end
    end

    // Error event reporting; a read error wins over a scrub error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.err_valid  <= 1'b0;
            bus.err_addr   <= '0;
            bus.err_src    <= ERR_SRC_READ;
            bus.scrub_done <= 1'b0;
        end else begin
            bus.err_valid  <= ev_any;
            bus.scrub_done <= done_nxt;
            if (rd_err_nxt) begin
                bus.err_addr <= bus.rd_addr;
                bus.err_src  <= ERR_SRC_READ;
            end else if (ev_sc) begin
                bus.err_addr <= scrub_addr;
                bus.err_src  <= ERR_SRC_SCRUB;
            end
        end
    end

    // Saturating error counter; a clear coinciding with an error leaves one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.err_count <= '0;
        end else if (bus.err_clr) begin
            bus.err_count <= ev_any ? 8'd1 : 8'd0;
        end else if (ev_any && bus.err_count != ERR_CNT_MAX) begin
            bus.err_count <= bus.err_count + 8'd1;
        end
    end

endmodule
